// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
// Holds the FSM state encoding, the bus command bundle and the timeout counter width.
package dmem_pkg;

  localparam int TIMEOUT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } dmem_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_cmd_t;

  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/bus_timer.sv
// Wait-state watchdog: counts enabled cycles, flags expiry combinationally on the LIMIT-th one.
// No handshake; clear has priority over enable.
module bus_timer
  import dmem_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(LIMIT - 1);

  logic [TIMEOUT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: posts stores through a 1-entry buffer, loads take >=3 cycles.
// Stalls the core while a load is in flight or any access meets a busy write buffer.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  dmem_state_t state, state_nxt;
  bus_cmd_t    cmd;

  logic access, legal, illegal;
  logic busy, ack_done, expired;
  logic stall_raw, issue_wr, issue_rd, flag_illegal;

  assign access  = mem_read | mem_write;
  assign legal   = (mem_read ^ mem_write) && (addr[1:0] == 2'b00);
  assign illegal = access && !legal;

  assign busy     = (state == WRITE) || (state == READ);
  assign ack_done = busy && bus_req && bus_ack;

  // Enable drops on ack, so a same-cycle ack always beats expiry.
  bus_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_bus_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!busy),
    .en     (busy && !bus_ack),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    stall_raw    = 1'b0;
    issue_wr     = 1'b0;
    issue_rd     = 1'b0;
    flag_illegal = 1'b0;
    case (state)
      IDLE: begin
        if (illegal) begin
          flag_illegal = 1'b1;
        end else if (legal && mem_write) begin
          issue_wr  = 1'b1;
          state_nxt = WRITE;
        end else if (legal && mem_read) begin
          issue_rd  = 1'b1;
          stall_raw = 1'b1;
          state_nxt = READ;
        end
      end
      WRITE: begin
        stall_raw = access;
        if (ack_done || expired) begin
          state_nxt = IDLE;
        end
      end
      READ: begin
        stall_raw = 1'b1;
        if (ack_done || expired) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Gated by reset so the core is released the moment reset asserts.
  assign stall = reset & stall_raw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd     <= '0;
      bus_req <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      if (flag_illegal || expired) begin
        err <= 1'b1;
      end
      if (issue_wr) begin
        bus_req <= 1'b1;
        cmd     <= '{we: 1'b1, addr: word_addr(addr), wdata: wdata};
      end else if (issue_rd) begin
        bus_req  <= 1'b1;
        cmd.we   <= 1'b0;
        cmd.addr <= word_addr(addr);
      end else if (ack_done || expired) begin
        bus_req <= 1'b0;
        cmd.we  <= 1'b0;
      end
      if (state == READ) begin
        if (ack_done) begin
          rdata <= bus_rdata;
        end else if (expired) begin
          rdata <= '0;
        end
      end
    end
  end

  assign bus_we    = cmd.we;
  assign bus_addr  = cmd.addr;
  assign bus_wdata = cmd.wdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized bench for data_mem_ctrl with a cycle-arithmetic reference model and a wait-state bus slave.
module tb_data_mem_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          delay_q[$];
  int          len_q[$];
  logic        txn_we_q[$];
  logic [31:0] txn_addr_q[$];
  logic [31:0] txn_data_q[$];
  logic [31:0] slave_mem[logic [31:0]];
  logic [31:0] model_mem[logic [31:0]];
  bit          in_txn = 0;
  bit          unstable = 0;
  int          cnt = 0;
  int          cur_delay = 0;
  logic [31:0] hold_addr, hold_wdata;
  logic        hold_we;
  int          last_wr_cyc = -100;
  int          last_wr_delay = 0;

  data_mem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .err(err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return dflt(a);
  endfunction

  // Stall cycles an access presented at cycle p should see: wait out any posted store
  // (busy for delay+1 cycles after the cycle it retired), then a load costs delay+2.
  function automatic int exp_stall(input bit is_load, input int d, input int p);
    int rem;
    rem = last_wr_cyc + last_wr_delay + 2 - p;
    if (rem < 0) rem = 0;
    return rem + (is_load ? d + 2 : 0);
  endfunction

  // Bus slave: acks after the queued number of wait cycles, logs every transaction.
  always @(negedge clk) begin
    if (bus_req === 1'b1) begin
      if (!in_txn) begin
        in_txn = 1;
        cnt = 0;
        cur_delay = 0;
        if (delay_q.size() > 0) cur_delay = delay_q.pop_front();
        hold_addr = bus_addr;
        hold_we = bus_we;
        hold_wdata = bus_wdata;
      end else if (bus_addr !== hold_addr || bus_we !== hold_we ||
                   (hold_we && bus_wdata !== hold_wdata)) begin
        unstable = 1;
      end
      if (cnt == cur_delay) begin
        bus_ack = 1'b1;
        if (bus_we) begin
          slave_mem[bus_addr] = bus_wdata;
          bus_rdata = $urandom;
          txn_data_q.push_back(bus_wdata);
        end else begin
          bus_rdata = slave_mem.exists(bus_addr) ? slave_mem[bus_addr] : dflt(bus_addr);
          txn_data_q.push_back(bus_rdata);
        end
        txn_we_q.push_back(bus_we);
        txn_addr_q.push_back(bus_addr);
      end else begin
        bus_ack = 1'b0;
        bus_rdata = $urandom;
      end
      cnt++;
    end else begin
      if (in_txn) begin
        len_q.push_back(cnt);
        in_txn = 0;
      end
      bus_ack = 1'b0;
    end
  end

  task automatic clear_logs();
    len_q.delete();
    txn_we_q.delete();
    txn_addr_q.delete();
    txn_data_q.delete();
    unstable = 0;
  endtask

  task automatic idle(input int n);
    mem_read = 1'b0;
    mem_write = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    mem_read = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    delay_q.delete();
    clear_logs();
    last_wr_cyc = -100;
  endtask

  // Presents one instruction and holds it until the core is released (bounded).
  task automatic run_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output int stalls, output logic [31:0] rv, output int start);
    mem_read = rd;
    mem_write = wr;
    addr = a;
    wdata = d;
    stalls = 0;
    @(negedge clk);
    start = cyc;
    while (stall === 1'b1 && stalls < 40) begin
      stalls++;
      @(negedge clk);
    end
    rv = rdata;
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic test_reset();
    mem_read = 1'b1;
    addr = 32'h40;
    #2;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req got %b want 0", bus_req); end
    checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL reset_bus_we got %b want 0", bus_we); end
    checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL reset_bus_addr got %h want 0", bus_addr); end
    checks++; if (bus_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus_wdata got %h want 0", bus_wdata); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_store_posted();
    int st, start;
    logic [31:0] rv;
    clear_logs();
    delay_q.push_back(2);
    run_op(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, st, rv, start);
    model_mem[32'h10] = 32'hCAFEF00D;
    checks++; if (st !== exp_stall(0, 0, start)) begin errors++; $display("FAIL store_stall got %0d want %0d", st, exp_stall(0, 0, start)); end
    last_wr_cyc = start + st;
    last_wr_delay = 2;
    idle(6);
    checks++; if (len_q.size() !== 1 || len_q[0] !== 3) begin errors++; $display("FAIL store_req_len got n=%0d len=%0d want 1x3", len_q.size(), len_q.size() ? len_q[0] : -1); end
    checks++; if (txn_we_q.size() !== 1 || txn_we_q[0] !== 1'b1 || txn_addr_q[0] !== 32'h10 || txn_data_q[0] !== 32'hCAFEF00D)
      begin errors++; $display("FAIL store_txn got n=%0d want one write 10/cafef00d", txn_we_q.size()); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL store_stable got unstable=%0d want 0", unstable); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL store_req_drop got %b want 0", bus_req); end
  endtask

  task automatic test_load_basic();
    int st, start, e;
    logic [31:0] rv;
    clear_logs();
    delay_q.push_back(0);
    run_op(1'b1, 1'b0, 32'h10, 32'h0, st, rv, start);
    e = exp_stall(1, 0, start);
    checks++; if (st !== e) begin errors++; $display("FAIL load_stall got %0d want %0d", st, e); end
    checks++; if (rv !== model_read(32'h10)) begin errors++; $display("FAIL load_rdata got %h want %h", rv, model_read(32'h10)); end
    idle(2);
    checks++; if (len_q.size() !== 1 || txn_we_q.size() !== 1 || txn_we_q[0] !== 1'b0 || txn_addr_q[0] !== 32'h10)
      begin errors++; $display("FAIL load_txn got n=%0d want one read of 10", txn_we_q.size()); end
  endtask

  task automatic test_back_to_back();
    int st, start, e;
    logic [31:0] rv, d;
    clear_logs();
    d = $urandom;
    delay_q.push_back(3);
    delay_q.push_back(1);
    run_op(1'b0, 1'b1, 32'h20, d, st, rv, start);
    model_mem[32'h20] = d;
    last_wr_cyc = start + exp_stall(0, 0, start);
    last_wr_delay = 3;
    run_op(1'b1, 1'b0, 32'h20, 32'h0, st, rv, start);
    e = exp_stall(1, 1, start);
    checks++; if (st !== e) begin errors++; $display("FAIL b2b_stall got %0d want %0d", st, e); end
    checks++; if (rv !== d) begin errors++; $display("FAIL b2b_rdata got %h want %h", rv, d); end
    idle(2);
    checks++; if (len_q.size() !== 2 || len_q[0] !== 4 || len_q[1] !== 2)
      begin errors++; $display("FAIL b2b_req_len got n=%0d want 4,2", len_q.size()); end
    checks++; if (txn_we_q.size() !== 2 || txn_we_q[0] !== 1'b1 || txn_we_q[1] !== 1'b0 || txn_addr_q[1] !== 32'h20)
      begin errors++; $display("FAIL b2b_txn got n=%0d want write then read of 20", txn_we_q.size()); end
  endtask

  task automatic test_random();
    int st, start, e, op, d;
    logic [31:0] a, v, rv;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      a = 32'h100 + 32'($urandom_range(0, 7)) * 4;
      d = $urandom_range(0, 3);
      v = $urandom;
      if (op == 0) begin
        idle($urandom_range(1, 3));
      end else if (op == 1) begin
        delay_q.push_back(d);
        run_op(1'b0, 1'b1, a, v, st, rv, start);
        e = exp_stall(0, 0, start);
        checks++; if (st !== e) begin errors++; $display("FAIL rand_store_stall i=%0d got %0d want %0d", i, st, e); end
        model_mem[a] = v;
        last_wr_cyc = start + e;
        last_wr_delay = d;
      end else begin
        delay_q.push_back(d);
        run_op(1'b1, 1'b0, a, 32'h0, st, rv, start);
        e = exp_stall(1, d, start);
        checks++; if (st !== e) begin errors++; $display("FAIL rand_load_stall i=%0d got %0d want %0d", i, st, e); end
        checks++; if (rv !== model_read(a)) begin errors++; $display("FAIL rand_load_rdata i=%0d got %h want %h", i, rv, model_read(a)); end
      end
    end
    idle(8);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rand_err got %b want 0", err); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL rand_stable got %0d want 0", unstable); end
    for (int k = 0; k < 8; k++) begin
      a = 32'h100 + 32'(k) * 4;
      if (model_mem.exists(a)) begin
        checks++;
        if (!slave_mem.exists(a) || slave_mem[a] !== model_mem[a]) begin
          errors++; $display("FAIL rand_mem addr=%h got %h want %h", a, slave_mem.exists(a) ? slave_mem[a] : 32'hx, model_mem[a]);
        end
      end
    end
  endtask

  task automatic test_illegal();
    int st, start, e;
    logic [31:0] rv;
    apply_reset();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL illegal_err_pre got %b want 0", err); end
    run_op(1'b1, 1'b0, 32'h13, 32'h0, st, rv, start);
    checks++; if (st !== 0) begin errors++; $display("FAIL misalign_stall got %0d want 0", st); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL misalign_err got %b want 1", err); end
    idle(3);
    checks++; if (len_q.size() !== 0) begin errors++; $display("FAIL misalign_no_req got %0d reqs want 0", len_q.size()); end

    apply_reset();
    run_op(1'b1, 1'b1, 32'h40, 32'h1234, st, rv, start);
    checks++; if (st !== 0) begin errors++; $display("FAIL rdwr_stall got %0d want 0", st); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL rdwr_err got %b want 1", err); end
    idle(3);
    checks++; if (len_q.size() !== 0) begin errors++; $display("FAIL rdwr_no_req got %0d reqs want 0", len_q.size()); end

    apply_reset();
    delay_q.push_back(2);
    run_op(1'b0, 1'b1, 32'h50, 32'h77, st, rv, start);
    model_mem[32'h50] = 32'h77;
    last_wr_cyc = start + exp_stall(0, 0, start);
    last_wr_delay = 2;
    run_op(1'b1, 1'b0, 32'h13, 32'h0, st, rv, start);
    e = exp_stall(0, 0, start);
    checks++; if (st !== e) begin errors++; $display("FAIL wr_busy_misalign_stall got %0d want %0d", st, e); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wr_busy_misalign_err got %b want 1", err); end
    idle(3);
    checks++; if (len_q.size() !== 1) begin errors++; $display("FAIL wr_busy_misalign_reqs got %0d want 1", len_q.size()); end
  endtask

  task automatic test_timeout();
    int st, start, e;
    logic [31:0] rv;
    apply_reset();
    delay_q.push_back(1);
    run_op(1'b1, 1'b0, 32'h30, 32'h0, st, rv, start);
    checks++; if (rv !== model_read(32'h30)) begin errors++; $display("FAIL to_pre_rdata got %h want %h", rv, model_read(32'h30)); end
    clear_logs();
    delay_q.push_back(100);
    run_op(1'b1, 1'b0, 32'h30, 32'h0, st, rv, start);
    e = TO + 1;
    checks++; if (st !== e) begin errors++; $display("FAIL to_stall got %0d want %0d", st, e); end
    checks++; if (rv !== 32'h0) begin errors++; $display("FAIL to_rdata got %h want 0", rv); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err got %b want 1", err); end
    idle(2);
    checks++; if (len_q.size() !== 1 || len_q[0] !== TO || txn_we_q.size() !== 0)
      begin errors++; $display("FAIL to_req_len got n=%0d want one of %0d unacked", len_q.size(), TO); end
    delay_q.push_back(3);
    run_op(1'b1, 1'b0, 32'h34, 32'h0, st, rv, start);
    checks++; if (st !== 5 || rv !== model_read(32'h34)) begin errors++; $display("FAIL to_recover got stall=%0d rdata=%h want 5/%h", st, rv, model_read(32'h34)); end
  endtask

  task automatic test_reset_mid_read();
    int st, start;
    logic [31:0] rv;
    delay_q.push_back(0);
    run_op(1'b1, 1'b0, 32'h3C, 32'h0, st, rv, start);
    delay_q.push_back(100);
    mem_read = 1'b1;
    addr = 32'h44;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL mid_read_req got %b want 1", bus_req); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL arst_bus_req got %b want 0", bus_req); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL arst_stall got %b want 0", stall); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL arst_rdata got %h want 0", rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL arst_err got %b want 0", err); end
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    delay_q.delete();
    clear_logs();
    last_wr_cyc = -100;
    delay_q.push_back(2);
    run_op(1'b1, 1'b0, 32'h44, 32'h0, st, rv, start);
    checks++; if (st !== exp_stall(1, 2, start)) begin errors++; $display("FAIL post_rst_stall got %0d want %0d", st, exp_stall(1, 2, start)); end
    checks++; if (rv !== model_read(32'h44)) begin errors++; $display("FAIL post_rst_rdata got %h want %h", rv, model_read(32'h44)); end
    idle(2);
    checks++; if (len_q.size() !== 1 || len_q[0] !== 3) begin errors++; $display("FAIL post_rst_req_len got n=%0d want 1x3", len_q.size()); end
  endtask

  initial begin
    test_reset();
    test_store_posted();
    test_load_basic();
    test_back_to_back();
    test_random();
    test_illegal();
    test_timeout();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
